// File: rtl/pc_sequencer_pkg.sv
// Shared core definitions for the PC sequencer: widths, state encoding,
// the sequential PC step, default vectors and the redirect payload.
package pc_sequencer_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_STEP              = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_TRAP  = 2'd3
  } state_e;

  // Control-flow request presented by the datapath at the end of an instruction
  typedef struct packed {
    logic            trap;
    logic            mret;
    logic            jump;
    logic [XLEN-1:0] jump_target;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
  } redirect_t;

  function automatic logic misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux with target alignment check; purely combinational.
module pc_next_sel
  import pc_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] mepc,
  input  redirect_t       redir,
  output logic [XLEN-1:0] next_pc_c,
  output logic            take_trap_c
);

  // Priority: trap > mret > jump > taken branch > sequential
  always_comb begin
    take_trap_c = 1'b0;
    next_pc_c   = pc + PC_STEP;
    if (redir.trap) begin
      take_trap_c = 1'b1;
    end else if (redir.mret) begin
      next_pc_c = mepc;
    end else if (redir.jump) begin
      if (misaligned(redir.jump_target)) take_trap_c = 1'b1;
      else                               next_pc_c   = redir.jump_target;
    end else if (redir.branch_taken) begin
      if (misaligned(redir.branch_target)) take_trap_c = 1'b1;
      else                                 next_pc_c   = redir.branch_target;
    end
    if (take_trap_c) next_pc_c = TRAP_VECTOR;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: boot/fetch/execute/trap control with
// registered PC, saved exception PC and fetch handshake outputs.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            imem_ready,
  input  logic            exec_done,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            trap,
  input  logic            mret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  output logic            instr_valid,
  output logic [XLEN-1:0] mepc
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic            imem_req_q, imem_req_d;
  logic            instr_valid_q, instr_valid_d;

  redirect_t       redir;
  logic [XLEN-1:0] sel_pc_c;
  logic            sel_trap_c;

  assign redir = '{trap:          trap,
                   mret:          mret,
                   jump:          jump,
                   jump_target:   jump_target,
                   branch_taken:  branch_taken,
                   branch_target: branch_target};

  pc_next_sel #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_pc_next_sel (
    .pc          (pc_q),
    .mepc        (mepc_q),
    .redir       (redir),
    .next_pc_c   (sel_pc_c),
    .take_trap_c (sel_trap_c)
  );

  // Next-state and register update logic; stall freezes every state
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    mepc_d        = mepc_q;
    instr_valid_d = 1'b0;
    if (!stall) begin
      unique case (state_q)
        ST_BOOT: state_d = ST_FETCH;
        ST_FETCH: begin
          if (imem_ready) begin
            instr_valid_d = 1'b1;
            state_d       = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            if (sel_trap_c) begin
              state_d = ST_TRAP;
            end else begin
              pc_d    = sel_pc_c;
              state_d = ST_FETCH;
            end
          end
        end
        ST_TRAP: begin
          mepc_d  = pc_q;
          pc_d    = TRAP_VECTOR;
          state_d = ST_FETCH;
        end
        default: state_d = ST_BOOT;
      endcase
    end
    imem_req_d = (state_d == ST_FETCH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_VECTOR;
      mepc_q        <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mepc_q        <= mepc_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Redirect target only matters while an instruction is executing
  assign pc_next     = (state_q == ST_EXEC) ? sel_pc_c : pc_q;
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign mepc        = mepc_q;
  assign imem_req    = imem_req_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed PC traces.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, imem_ready, exec_done;
  logic        branch_taken, jump, trap, mret;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, pc_next, imem_addr, mepc;
  logic        imem_req, instr_valid;

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .imem_ready    (imem_ready),
    .exec_done     (exec_done),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .trap          (trap),
    .mret          (mret),
    .pc            (pc),
    .pc_next       (pc_next),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .instr_valid   (instr_valid),
    .mepc          (mepc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // In FETCH: return the word, expect the valid pulse in the first EXEC cycle
  task automatic fetch_word(input string tag);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    check_eq({tag, "_ivalid"}, 32'(instr_valid), 32'd1);
    check_eq({tag, "_req_exec"}, 32'(imem_req), 32'd0);
  endtask

  // In EXEC: present completion plus redirect, check pc_next, take the edge
  task automatic exec_instr(input string tag, input logic t, input logic m,
                            input logic j, input logic [31:0] jt,
                            input logic b, input logic [31:0] bt,
                            input logic [31:0] exp_next);
    exec_done = 1'b1; trap = t; mret = m;
    jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
    #1 check_eq({tag, "_pc_next"}, pc_next, exp_next);
    step();
    exec_done = 1'b0; trap = 1'b0; mret = 1'b0; jump = 1'b0; branch_taken = 1'b0;
  endtask

  // Sequential fetch+exec expecting landing in FETCH at exp_pc
  task automatic run_seq(input string tag, input logic [31:0] exp_pc);
    fetch_word(tag);
    exec_instr(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, exp_pc);
    check_eq({tag, "_pc"}, pc, exp_pc);
    check_eq({tag, "_req"}, 32'(imem_req), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; imem_ready = 1'b0; exec_done = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; trap = 1'b0; mret = 1'b0;
    branch_target = '0; jump_target = '0;
    step(); step();
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_mepc", mepc, 32'h0);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_ivalid", 32'(instr_valid), 32'd0);
    check_eq("rst_pc_next", pc_next, 32'h0);

    rst = 1'b1;
    step();
    check_eq("boot_req", 32'(imem_req), 32'd1);
    check_eq("boot_addr", imem_addr, 32'h0);
    check_eq("fetch_ivalid0", 32'(instr_valid), 32'd0);

    // Three sequential instructions then one more to reach 0x10
    run_seq("seq1", 32'h4);
    run_seq("seq2", 32'h8);
    run_seq("seq3", 32'hC);
    run_seq("seq4", 32'h10);

    // Jump outranks taken branch
    fetch_word("jb");
    exec_instr("jb", 1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h40, 32'h80);
    check_eq("jb_pc", pc, 32'h80);

    fetch_word("j20");
    exec_instr("j20", 1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 32'h20);
    check_eq("j20_pc", pc, 32'h20);

    // Misaligned jump traps
    fetch_word("mis");
    exec_instr("mis", 1'b0, 1'b0, 1'b1, 32'h22, 1'b0, 32'h0, 32'h100);
    check_eq("mis_trap_pc", pc, 32'h20);
    check_eq("mis_trap_req", 32'(imem_req), 32'd0);
    check_eq("mis_trap_pc_next", pc_next, 32'h20);
    step();
    check_eq("mis_mepc", mepc, 32'h20);
    check_eq("mis_tvec", pc, 32'h100);
    check_eq("mis_fetch_req", 32'(imem_req), 32'd1);
    check_eq("mis_fetch_addr", imem_addr, 32'h100);

    // mret returns to saved PC
    fetch_word("mret1");
    exec_instr("mret1", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h20);
    check_eq("mret1_pc", pc, 32'h20);

    // Build mepc=0xFFFFFFFC via an explicit trap there, then mret and wrap
    fetch_word("jtop");
    exec_instr("jtop", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'hFFFF_FFFC);
    check_eq("jtop_pc", pc, 32'hFFFF_FFFC);
    fetch_word("ecall");
    exec_instr("ecall", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8, 32'h100);
    step();
    check_eq("ecall_mepc", mepc, 32'hFFFF_FFFC);
    check_eq("ecall_pc", pc, 32'h100);
    fetch_word("mret2");
    exec_instr("mret2", 1'b0, 1'b1, 1'b1, 32'h44, 1'b0, 32'h0, 32'hFFFF_FFFC);
    check_eq("mret2_pc", pc, 32'hFFFF_FFFC);
    run_seq("wrap", 32'h0);

    // Stall in FETCH keeps request up and blocks the valid pulse
    stall = 1'b1; imem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("stf_req", 32'(imem_req), 32'd1);
      check_eq("stf_ivalid", 32'(instr_valid), 32'd0);
    end
    stall = 1'b0; imem_ready = 1'b0;
    fetch_word("stx");
    // Stall in EXEC with exec_done held
    stall = 1'b1; exec_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("stx_pc", pc, 32'h0);
      check_eq("stx_req", 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    step();
    exec_done = 1'b0;
    check_eq("stx_release_pc", pc, 32'h4);
    check_eq("stx_release_req", 32'(imem_req), 32'd1);

    // Async reset mid-fetch at 0x8
    run_seq("pre_rst", 32'h8);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_pc", pc, 32'h0);
    check_eq("arst_req", 32'(imem_req), 32'd0);
    check_eq("arst_mepc", mepc, 32'h0);
    step();
    rst = 1'b1;
    step();
    check_eq("reboot_req", 32'(imem_req), 32'd1);

    // Async reset in TRAP discards the pending mepc/pc update
    fetch_word("j44");
    exec_instr("j44", 1'b0, 1'b0, 1'b1, 32'h44, 1'b0, 32'h0, 32'h44);
    fetch_word("t44");
    exec_instr("t44", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
    check_eq("t44_pc", pc, 32'h44);
    #2 rst = 1'b0;
    #1;
    check_eq("trst_pc", pc, 32'h0);
    check_eq("trst_mepc", mepc, 32'h0);
    step();
    check_eq("trst_hold_mepc", mepc, 32'h0);
    rst = 1'b1;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
